// File: rtl/tx_ds_pkg.sv
// ---------------------------------------------------------------------------
// tx_ds_pkg
// Shared definitions for the DS link transmit scheduler:
//   - control-code values carried in dat_o[1:0] when lchar_o is high
//   - scheduler state encoding
//   - default credit ceiling and per-FCT credit step
//   - helper that widens a 2-bit control code to a full output byte
// ---------------------------------------------------------------------------
package tx_ds_pkg;

    localparam int CREDIT_W         = 6;
    localparam int CREDIT_MAX_DEF   = 56;
    localparam int CREDIT_STEP_DEF  = 8;

    localparam logic [1:0] CODE_FCT = 2'b00;
    localparam logic [1:0] CODE_EOP = 2'b01;
    localparam logic [1:0] CODE_EEP = 2'b10;
    localparam logic [1:0] CODE_ESC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ESC_NULL = 2'd1,
        ST_ESC_TIME = 2'd2
    } sched_state_t;

    // Control characters always carry zeros above the 2-bit code.
    function automatic logic [7:0] ctrl_byte(input logic [1:0] code);
        return {6'b000000, code};
    endfunction

endpackage

// File: rtl/tx_ds_credit.sv
// ---------------------------------------------------------------------------
// tx_ds_credit
// Transmit credit counter with sticky overflow flag.
// Ports:
//   TxClk, TxReset_n   clock, async active-low reset
//   credit_add         one-cycle pulse: far end granted CREDIT_STEP more N-chars
//   credit_take        one-cycle pulse: an N-char was issued (consumes one)
//   credit             current credit count
//   credit_err         set when a grant would exceed CREDIT_MAX; held until reset
// ---------------------------------------------------------------------------
module tx_ds_credit
    import tx_ds_pkg::*;
#(
    parameter int CREDIT_MAX  = CREDIT_MAX_DEF,
    parameter int CREDIT_STEP = CREDIT_STEP_DEF
) (
    input  logic                TxClk,
    input  logic                TxReset_n,
    input  logic                credit_add,
    input  logic                credit_take,
    output logic [CREDIT_W-1:0] credit,
    output logic                credit_err
);

    logic [CREDIT_W:0] credit_net;
    logic              add_overflow;

    // Net result of a grant combined with a same-cycle issue. One extra bit
    // keeps the sum from wrapping before it is compared to the ceiling.
    // credit_take only arrives with credit > 0, so the subtraction never
    // goes below zero.
    always_comb begin
        credit_net   = {1'b0, credit} + (CREDIT_W+1)'(CREDIT_STEP)
                       - {{CREDIT_W{1'b0}}, credit_take};
        add_overflow = credit_add && (credit_net > (CREDIT_W+1)'(CREDIT_MAX));
    end

    // A rejected grant leaves the count alone except for a character that
    // really went out in the same cycle, which must still be paid for.
    always_ff @(posedge TxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            credit     <= '0;
            credit_err <= 1'b0;
        end else begin
            if (credit_add && !add_overflow) begin
                credit <= credit_net[CREDIT_W-1:0];
            end else if (credit_take) begin
                credit <= credit - 1'b1;
            end
            if (add_overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_ds_sched.sv
// ---------------------------------------------------------------------------
// tx_ds_sched
// Chooses the next character for the DS character transmitter.
// Ports:
//   TxClk, TxReset_n             clock, async active-low reset
//   null_en_i/fct_en_i/dat_en_i  link-state gates for NULL, FCT, data/time
//   fct_req_i / fct_ack_o        FCT request level / issue pulse
//   time_valid_i, time_i         time-code request level and byte
//   time_ack_o                   pulse when the time byte goes out
//   dat_valid_i, dat_i           N-char request level and 9-bit N-char
//   dat_ready_o                  pop strobe when the N-char goes out
//   credit_add_i                 FCT received by far end
//   credit_o, credit_err_o       credit count and sticky overflow
//   valid_o, dat_o, lchar_o      registered character to the transmitter
//   ready_i                      transmitter idle
// ---------------------------------------------------------------------------
module tx_ds_sched
    import tx_ds_pkg::*;
#(
    parameter int CREDIT_MAX  = CREDIT_MAX_DEF,
    parameter int CREDIT_STEP = CREDIT_STEP_DEF
) (
    input  logic                TxClk,
    input  logic                TxReset_n,
    input  logic                null_en_i,
    input  logic                fct_en_i,
    input  logic                dat_en_i,
    input  logic                fct_req_i,
    output logic                fct_ack_o,
    input  logic                time_valid_i,
    input  logic [7:0]          time_i,
    output logic                time_ack_o,
    input  logic                dat_valid_i,
    input  logic [8:0]          dat_i,
    output logic                dat_ready_o,
    input  logic                credit_add_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                credit_err_o,
    output logic                valid_o,
    output logic [7:0]          dat_o,
    output logic                lchar_o,
    input  logic                ready_i
);

    sched_state_t state, state_next;

    logic [7:0] time_q;
    logic       time_load;
    logic       credit_take;
    logic       can_issue;
    logic       time_go, fct_go, dat_go;

    logic       valid_next, lchar_next;
    logic [7:0] dat_next;
    logic       fct_ack_next, time_ack_next, dat_ready_next;

    tx_ds_credit #(
        .CREDIT_MAX  (CREDIT_MAX),
        .CREDIT_STEP (CREDIT_STEP)
    ) u_credit (
        .TxClk       (TxClk),
        .TxReset_n   (TxReset_n),
        .credit_add  (credit_add_i),
        .credit_take (credit_take),
        .credit      (credit_o),
        .credit_err  (credit_err_o)
    );

    // Gating on valid_o forces at least one idle cycle between characters,
    // which also gives the transmitter time to drop ready_i.
    always_comb begin
        can_issue = !valid_o && ready_i;
        time_go   = time_valid_i && dat_en_i;
        fct_go    = fct_req_i && fct_en_i;
        dat_go    = dat_valid_i && dat_en_i && (credit_o != '0);
    end

    // Next-state and next-character selection. The ESC states finish their
    // second character unconditionally so a NULL or time-code is never split.
    always_comb begin
        state_next     = state;
        valid_next     = 1'b0;
        dat_next       = 8'h00;
        lchar_next     = 1'b0;
        fct_ack_next   = 1'b0;
        time_ack_next  = 1'b0;
        dat_ready_next = 1'b0;
        time_load      = 1'b0;
        credit_take    = 1'b0;

        if (can_issue) begin
            case (state)
                ST_IDLE: begin
                    if (time_go) begin
                        valid_next = 1'b1;
                        lchar_next = 1'b1;
                        dat_next   = ctrl_byte(CODE_ESC);
                        time_load  = 1'b1;
                        state_next = ST_ESC_TIME;
                    end else if (fct_go) begin
                        valid_next   = 1'b1;
                        lchar_next   = 1'b1;
                        dat_next     = ctrl_byte(CODE_FCT);
                        fct_ack_next = 1'b1;
                    end else if (dat_go) begin
                        valid_next     = 1'b1;
                        dat_ready_next = 1'b1;
                        credit_take    = 1'b1;
                        if (dat_i[8]) begin
                            lchar_next = 1'b1;
                            dat_next   = ctrl_byte(dat_i[0] ? CODE_EEP : CODE_EOP);
                        end else begin
                            dat_next   = dat_i[7:0];
                        end
                    end else if (null_en_i) begin
                        valid_next = 1'b1;
                        lchar_next = 1'b1;
                        dat_next   = ctrl_byte(CODE_ESC);
                        state_next = ST_ESC_NULL;
                    end
                end
                ST_ESC_NULL: begin
                    valid_next = 1'b1;
                    lchar_next = 1'b1;
                    dat_next   = ctrl_byte(CODE_FCT);
                    state_next = ST_IDLE;
                end
                ST_ESC_TIME: begin
                    valid_next    = 1'b1;
                    dat_next      = time_q;
                    time_ack_next = 1'b1;
                    state_next    = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched time byte and the registered character interface.
    always_ff @(posedge TxClk or negedge TxReset_n) begin
        if (!TxReset_n) begin
            state       <= ST_IDLE;
            time_q      <= 8'h00;
            valid_o     <= 1'b0;
            dat_o       <= 8'h00;
            lchar_o     <= 1'b0;
            fct_ack_o   <= 1'b0;
            time_ack_o  <= 1'b0;
            dat_ready_o <= 1'b0;
        end else begin
            state       <= state_next;
            if (time_load) begin
                time_q <= time_i;
            end
            valid_o     <= valid_next;
            dat_o       <= dat_next;
            lchar_o     <= lchar_next;
            fct_ack_o   <= fct_ack_next;
            time_ack_o  <= time_ack_next;
            dat_ready_o <= dat_ready_next;
        end
    end

endmodule

// File: tb/tb_tx_ds_sched.sv
// ---------------------------------------------------------------------------
// tb_tx_ds_sched
// Directed bench for tx_ds_sched: NULL stream, N-char issue and credit,
// time-code with FCT, FCT-over-data priority, credit ceiling, zero credit,
// and reset in the middle of a time-code.
// ---------------------------------------------------------------------------
module tb_tx_ds_sched;

    logic       TxClk = 1'b0;
    logic       TxReset_n = 1'b0;
    logic       null_en_i, fct_en_i, dat_en_i;
    logic       fct_req_i, fct_ack_o;
    logic       time_valid_i, time_ack_o;
    logic [7:0] time_i;
    logic       dat_valid_i, dat_ready_o;
    logic [8:0] dat_i;
    logic       credit_add_i;
    logic [5:0] credit_o;
    logic       credit_err_o;
    logic       valid_o, lchar_o, ready_i;
    logic [7:0] dat_o;

    int total = 0;
    int bad   = 0;

    logic       got, l, fa, ta, dr;
    logic [7:0] d;
    int         waited;

    always #5 TxClk = ~TxClk;

    tx_ds_sched #(.CREDIT_MAX(56), .CREDIT_STEP(8)) dut (
        .TxClk        (TxClk),
        .TxReset_n    (TxReset_n),
        .null_en_i    (null_en_i),
        .fct_en_i     (fct_en_i),
        .dat_en_i     (dat_en_i),
        .fct_req_i    (fct_req_i),
        .fct_ack_o    (fct_ack_o),
        .time_valid_i (time_valid_i),
        .time_i       (time_i),
        .time_ack_o   (time_ack_o),
        .dat_valid_i  (dat_valid_i),
        .dat_i        (dat_i),
        .dat_ready_o  (dat_ready_o),
        .credit_add_i (credit_add_i),
        .credit_o     (credit_o),
        .credit_err_o (credit_err_o),
        .valid_o      (valid_o),
        .dat_o        (dat_o),
        .lchar_o      (lchar_o),
        .ready_i      (ready_i)
    );

    task automatic clear_inputs;
        null_en_i = 0; fct_en_i = 0; dat_en_i = 0;
        fct_req_i = 0; time_valid_i = 0; time_i = 8'h00;
        dat_valid_i = 0; dat_i = 9'h000; credit_add_i = 0;
        ready_i = 1;
    endtask

    task automatic do_reset;
        clear_inputs();
        TxReset_n = 0;
        repeat (2) @(posedge TxClk);
        #1 TxReset_n = 1;
    endtask

    task automatic pulse_add(input int n);
        repeat (n) begin
            @(posedge TxClk); #1 credit_add_i = 1;
            @(posedge TxClk); #1 credit_add_i = 0;
        end
    endtask

    // Waits (bounded) for the next valid_o cycle and captures the character.
    task automatic wait_char(output logic g, output logic [7:0] dd, output logic ll,
                             output logic ffa, output logic tta, output logic ddr,
                             output int w);
        g = 0; dd = 0; ll = 0; ffa = 0; tta = 0; ddr = 0; w = 0;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge TxClk);
            w = i + 1;
            if (valid_o === 1'b1) begin
                g = 1; dd = dat_o; ll = lchar_o;
                ffa = fct_ack_o; tta = time_ack_o; ddr = dat_ready_o;
            end
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        null_en_i = 1; dat_en_i = 1; dat_valid_i = 1;
        TxReset_n = 0;
        #1;
        total++;
        if ({valid_o, dat_o, lchar_o, fct_ack_o, time_ack_o, dat_ready_o} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {valid_o, dat_o, lchar_o, fct_ack_o, time_ack_o, dat_ready_o});
        end
        total++;
        if ({credit_o, credit_err_o} !== 7'h0) begin
            bad++;
            $display("FAIL reset_credit got=%h want=0", {credit_o, credit_err_o});
        end
    endtask

    task automatic test_null_stream;
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h03, 8'h00, 8'h03, 8'h00};
        do_reset();
        null_en_i = 1;
        for (int k = 0; k < 4; k++) begin
            wait_char(got, d, l, fa, ta, dr, waited);
            total++;
            if ({got, l, d, fa} !== {1'b1, 1'b1, exp_seq[k], 1'b0}) begin
                bad++;
                $display("FAIL null_char%0d got=%b/%b/%h/%b want=1/1/%h/0", k, got, l, d, fa, exp_seq[k]);
            end
            if (k > 0) begin
                total++;
                if (waited !== 2) begin
                    bad++;
                    $display("FAIL null_gap%0d got=%0d want=2", k, waited);
                end
            end
        end
        total++;
        if (credit_o !== 6'd0) begin
            bad++;
            $display("FAIL null_credit got=%0d want=0", credit_o);
        end
    endtask

    task automatic test_nchar;
        do_reset();
        dat_en_i = 1;
        pulse_add(2);
        #1;
        total++;
        if (credit_o !== 6'd16) begin
            bad++;
            $display("FAIL nchar_credit16 got=%0d want=16", credit_o);
        end
        dat_i = 9'h0A5; dat_valid_i = 1;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, dr} !== {1'b1, 1'b0, 8'hA5, 1'b1}) begin
            bad++;
            $display("FAIL nchar_A5 got=%b/%b/%h/%b want=1/0/a5/1", got, l, d, dr);
        end
        total++;
        if (credit_o !== 6'd15) begin
            bad++;
            $display("FAIL nchar_credit15 got=%0d want=15", credit_o);
        end
        @(posedge TxClk); #1 dat_i = 9'h100;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, dr} !== {1'b1, 1'b1, 8'h01, 1'b1}) begin
            bad++;
            $display("FAIL nchar_EOP got=%b/%b/%h/%b want=1/1/01/1", got, l, d, dr);
        end
        total++;
        if (credit_o !== 6'd14) begin
            bad++;
            $display("FAIL nchar_credit14 got=%0d want=14", credit_o);
        end
        @(posedge TxClk); #1 dat_i = 9'h101;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, dr} !== {1'b1, 1'b1, 8'h02, 1'b1}) begin
            bad++;
            $display("FAIL nchar_EEP got=%b/%b/%h/%b want=1/1/02/1", got, l, d, dr);
        end
        @(posedge TxClk); #1 dat_valid_i = 0;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if (got !== 1'b0 || credit_o !== 6'd13) begin
            bad++;
            $display("FAIL nchar_idle got=%b/%0d want=0/13", got, credit_o);
        end
    endtask

    task automatic test_time_fct;
        do_reset();
        dat_en_i = 1; fct_en_i = 1;
        time_i = 8'h3C; time_valid_i = 1;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, fa, ta} !== {1'b1, 1'b1, 8'h03, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL time_esc got=%b/%b/%h/%b/%b want=1/1/03/0/0", got, l, d, fa, ta);
        end
        @(posedge TxClk); #1 fct_req_i = 1; time_i = 8'hFF;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, fa, ta} !== {1'b1, 1'b0, 8'h3C, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL time_byte got=%b/%b/%h/%b/%b want=1/0/3c/0/1", got, l, d, fa, ta);
        end
        @(posedge TxClk); #1 time_valid_i = 0;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, fa, ta} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL time_fct got=%b/%b/%h/%b/%b want=1/1/00/1/0", got, l, d, fa, ta);
        end
        @(posedge TxClk); #1 fct_req_i = 0;
    endtask

    task automatic test_priority;
        do_reset();
        dat_en_i = 1; fct_en_i = 1;
        pulse_add(1);
        fct_req_i = 1; dat_valid_i = 1; dat_i = 9'h0C3;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, fa, dr} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL prio_fct got=%b/%b/%h/%b/%b want=1/1/00/1/0", got, l, d, fa, dr);
        end
        @(posedge TxClk); #1 fct_req_i = 0;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, fa, dr} !== {1'b1, 1'b0, 8'hC3, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL prio_data got=%b/%b/%h/%b/%b want=1/0/c3/0/1", got, l, d, fa, dr);
        end
        @(posedge TxClk); #1 dat_valid_i = 0;
    endtask

    task automatic test_credit_limits;
        int misses;
        do_reset();
        pulse_add(7);
        #1;
        total++;
        if ({credit_o, credit_err_o} !== {6'd56, 1'b0}) begin
            bad++;
            $display("FAIL limit_fill got=%0d/%b want=56/0", credit_o, credit_err_o);
        end
        dat_en_i = 1; dat_i = 9'h011; dat_valid_i = 1;
        misses = 0;
        for (int k = 0; k < 7; k++) begin
            wait_char(got, d, l, fa, ta, dr, waited);
            if (got !== 1'b1 || d !== 8'h11) misses++;
        end
        total++;
        if (misses !== 0 || credit_o !== 6'd49) begin
            bad++;
            $display("FAIL limit_drain got=%0d/%0d want=0/49", misses, credit_o);
        end
        @(posedge TxClk); #1 credit_add_i = 1;
        @(posedge TxClk); #1 credit_add_i = 0; dat_valid_i = 0;
        @(negedge TxClk);
        total++;
        if ({valid_o, dat_ready_o, credit_o, credit_err_o} !== {1'b1, 1'b1, 6'd56, 1'b0}) begin
            bad++;
            $display("FAIL limit_add_and_take got=%b/%b/%0d/%b want=1/1/56/0",
                     valid_o, dat_ready_o, credit_o, credit_err_o);
        end
        pulse_add(1);
        @(negedge TxClk);
        total++;
        if ({credit_o, credit_err_o} !== {6'd56, 1'b1}) begin
            bad++;
            $display("FAIL limit_overflow got=%0d/%b want=56/1", credit_o, credit_err_o);
        end
        repeat (3) @(negedge TxClk);
        total++;
        if (credit_err_o !== 1'b1) begin
            bad++;
            $display("FAIL limit_sticky got=%b want=1", credit_err_o);
        end
    endtask

    task automatic test_zero_credit;
        int data_pops;
        do_reset();
        null_en_i = 1; dat_en_i = 1; dat_valid_i = 1; dat_i = 9'h055;
        data_pops = 0;
        for (int k = 0; k < 4; k++) begin
            wait_char(got, d, l, fa, ta, dr, waited);
            total++;
            if ({got, l, d} !== {1'b1, 1'b1, ((k % 2) == 0) ? 8'h03 : 8'h00}) begin
                bad++;
                $display("FAIL zero_null%0d got=%b/%b/%h", k, got, l, d);
            end
            if (dr === 1'b1) data_pops++;
        end
        total++;
        if (data_pops !== 0 || credit_o !== 6'd0) begin
            bad++;
            $display("FAIL zero_pops got=%0d/%0d want=0/0", data_pops, credit_o);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        do_reset();
        dat_en_i = 1; time_i = 8'h5A; time_valid_i = 1;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d} !== {1'b1, 1'b1, 8'h03}) begin
            bad++;
            $display("FAIL mid_esc got=%b/%b/%h want=1/1/03", got, l, d);
        end
        TxReset_n = 0;
        #1;
        total++;
        if ({valid_o, dat_o, lchar_o, fct_ack_o, time_ack_o, dat_ready_o} !== 13'h0) begin
            bad++;
            $display("FAIL mid_async got=%h want=0",
                     {valid_o, dat_o, lchar_o, fct_ack_o, time_ack_o, dat_ready_o});
        end
        clear_inputs();
        dat_en_i = 1;
        repeat (2) @(posedge TxClk);
        #1 TxReset_n = 1;
        seen = 0;
        repeat (4) begin
            @(negedge TxClk);
            if (valid_o !== 1'b0 || time_ack_o !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL mid_quiet got=%0d want=0", seen);
        end
        null_en_i = 1;
        wait_char(got, d, l, fa, ta, dr, waited);
        total++;
        if ({got, l, d, ta} !== {1'b1, 1'b1, 8'h03, 1'b0}) begin
            bad++;
            $display("FAIL mid_idle got=%b/%b/%h/%b want=1/1/03/0", got, l, d, ta);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_null_stream();
        test_nchar();
        test_time_fct();
        test_priority();
        test_credit_limits();
        test_zero_credit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_ds_sched.md
TX_DS_SCHED -- requirements
Module: tx_DS_sched

Interface
REQ-001 Parameter CREDIT_MAX, default 56: ceiling of transmit credit counter, in N-chars.
REQ-002 Parameter CREDIT_STEP, default 8: credit added per credit_add_i pulse.
REQ-003 TxClk  in  1  sole clock; all state changes on rising edge.
REQ-004 TxReset_n  in  1  reset, asynchronous, active-low.
REQ-005 null_en_i / fct_en_i / dat_en_i  in  1 each  link-state gates for NULL, FCT, and N-char/time-code issue.
REQ-006 fct_req_i  in  1  level; request one FCT. fct_ack_o  out  1  one-cycle pulse when that FCT issues.
REQ-007 time_valid_i  in  1  level; time_i  in  8  time-code byte. time_ack_o  out  1  one-cycle pulse when the time byte issues.
REQ-008 dat_valid_i  in  1  level; dat_i  in  9  N-char (bit8=1: end marker, bit0=0 EOP, bit0=1 EEP). dat_ready_o  out  1  one-cycle pop strobe when the N-char issues.
REQ-009 credit_add_i  in  1  one-cycle pulse, FCT received by far end.
REQ-010 credit_o  out  6  current credit. credit_err_o  out  1  sticky credit overflow.
REQ-011 valid_o  out  1; dat_o  out  8; lchar_o  out  1  character to DS character transmitter. ready_i  in  1  transmitter idle (low while valid_o high).

Function
REQ-012 Control codes in dat_o[1:0] with lchar_o=1: FCT=00, EOP=01, EEP=10, ESC=11; dat_o[7:2]=0.
REQ-013 valid_o, dat_o, lchar_o registered; valid_o high exactly one cycle per character.
REQ-014 Issue in cycle N+1 only if valid_o=0 and ready_i=1 in cycle N; never in consecutive cycles.
REQ-015 States: IDLE, ESC_NULL, ESC_TIME.
REQ-016 IDLE priority, first eligible wins: time-code (time_valid_i & dat_en_i) > FCT (fct_req_i & fct_en_i) > N-char (dat_valid_i & dat_en_i & credit_o>0) > NULL (null_en_i).
REQ-017 Time-code: issue ESC, latch time_i, go ESC_TIME; next issue sends latched byte with lchar_o=0, pulses time_ack_o, returns IDLE.
REQ-018 NULL: issue ESC, go ESC_NULL; next issue sends FCT code, no fct_ack_o, no credit change, returns IDLE.
REQ-019 ESC_NULL/ESC_TIME complete the second character regardless of enables or higher-priority requests; a two-character sequence is never split.
REQ-020 FCT: issue FCT code, pulse fct_ack_o in issue cycle.
REQ-021 N-char: dat_i[8]=0 -> lchar_o=0, dat_o=dat_i[7:0]; dat_i[8]=1 -> EOP/EEP code; pulse dat_ready_o; credit decrements by 1.
REQ-022 credit_add_i: credit += CREDIT_STEP if result <= CREDIT_MAX; otherwise credit unchanged, credit_err_o set until reset.
REQ-023 Simultaneous add and N-char issue: net +CREDIT_STEP-1; overflow judged on net result.
REQ-024 No eligible request in IDLE: valid_o stays 0, state unchanged.

Reset
REQ-025 TxReset_n low asynchronously forces: state IDLE, valid_o=0, dat_o=0, lchar_o=0, fct_ack_o=0, time_ack_o=0, dat_ready_o=0, credit_o=0, credit_err_o=0, latched time byte=0.
REQ-026 Reset mid-sequence abandons it; no ack pulses for the aborted request.
REQ-027 First issue after deassertion requires one cycle observing ready_i=1.

Structure
REQ-028 Package tx_DS_pkg holds control-code constants, state encoding, CREDIT_MAX/CREDIT_STEP defaults.
REQ-029 Credit counter and overflow flag in sub-module tx_DS_credit; scheduler FSM in tx_DS_sched.

Verification
REQ-030 null_en_i=1, no requests, ready_i=1 -> ESC(11), FCT(00) repeating, each valid_o pulse separated by >=1 cycle.
REQ-031 credit_add_i x2, dat_valid_i with 0xA5 then 0x100 -> credit 16; 0xA5 lchar=0, then EOP(01); credit 14; two dat_ready_o pulses.
REQ-032 time_valid_i, time_i=0x3C, fct_req_i raised during ESC -> ESC, 0x3C lchar=0, time_ack_o, then FCT with fct_ack_o.
REQ-033 credit at 56, credit_add_i -> credit stays 56, credit_err_o=1; same-cycle add with N-char at 49 -> 56, no error.
REQ-034 dat_valid_i with credit 0 -> no N-char; NULLs continue if null_en_i=1.
REQ-035 TxReset_n low in ESC_TIME -> all outputs zero immediately; no time_ack_o; IDLE after release.
